// File: rtl/fft_sample_loader.sv
// Streams signed samples into N_BANK write ports that feed the FFT buffer, then
// launches the FFT and waits for its done level before accepting the next frame.
module fft_sample_loader #(
  parameter int DATA_W = 16,
  parameter int N_BANK = 4,
  parameter int DEPTH  = 512
) (
  input  logic                              iCLK,
  input  logic                              iRESET,
  input  logic [DATA_W-1:0]                 iDATA,
  input  logic                              iVALID,
  output logic                              oREADY,
  input  logic                              iMODE,
  input  logic                              iBITREV,
  output logic [DATA_W-1:0]                 oDATA,
  output logic [N_BANK*$clog2(DEPTH)-1:0]   oADDR_WR,
  output logic [N_BANK-1:0]                 oWE,
  output logic                              oSTART,
  input  logic                              iFFT_RDY,
  output logic                              oBUSY,
  output logic [7:0]                        oFRAME_CNT
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int BANK_W = (N_BANK > 1) ? $clog2(N_BANK) : 1;
  localparam int IDX_W  = ADDR_W + BANK_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BANK * DEPTH - 1);

  typedef enum logic [1:0] {
    S_FILL,
    S_LAUNCH,
    S_WAIT_FFT
  } state_t;

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       mode_q, mode_d;
  logic                       bitrev_q, bitrev_d;
  logic [DATA_W-1:0]          data_q, data_d;
  logic [N_BANK-1:0]          we_q, we_d;
  logic [N_BANK*ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]                 frame_cnt_q, frame_cnt_d;

  logic                       ready;
  logic                       accept;
  logic                       eff_mode;
  logic                       eff_bitrev;
  logic                       interleave;
  logic [BANK_W-1:0]          wr_bank;
  logic [ADDR_W-1:0]          lin_addr;
  logic [ADDR_W-1:0]          wr_addr;

  function automatic logic [ADDR_W-1:0] bit_reverse(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) r[i] = a[ADDR_W-1-i];
    return r;
  endfunction

  // --- FSM: state register ---
  always_ff @(posedge iCLK) begin
    // NOTE: sequential state is assigned with <= so every register samples the
    // pre-edge values regardless of statement order.
    if (iRESET) state_q <= S_FILL;
    else        state_q <= state_d;
  end

  // --- FSM: next-state logic ---
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_FILL:     if (accept && idx_q == LAST_IDX) state_d = S_LAUNCH;
      S_LAUNCH:   state_d = S_WAIT_FFT;
      S_WAIT_FFT: if (iFFT_RDY) state_d = S_FILL;
      default:    state_d = S_FILL;
    endcase
  end

  // --- FSM: outputs ---
  always_comb begin
    ready  = (state_q == S_FILL) && !iRESET;
    oSTART = (state_q == S_LAUNCH);
    oBUSY  = !((state_q == S_FILL) && (idx_q == '0));
  end

  assign accept = iVALID && ready;

  // The first sample of a frame uses the live mode pins; later ones the latched copy.
  assign eff_mode   = (idx_q == '0) ? iMODE   : mode_q;
  assign eff_bitrev = (idx_q == '0) ? iBITREV : bitrev_q;
  assign interleave = eff_mode && (N_BANK > 1);

  always_comb begin
    if (interleave) begin
      wr_bank  = idx_q[BANK_W-1:0];
      lin_addr = idx_q[IDX_W-1:BANK_W];
    end else begin
      wr_bank  = idx_q[IDX_W-1:ADDR_W];
      lin_addr = idx_q[ADDR_W-1:0];
    end
    wr_addr = eff_bitrev ? bit_reverse(lin_addr) : lin_addr;
  end

  // --- datapath next-state ---
  always_comb begin
    idx_d       = idx_q;
    mode_d      = mode_q;
    bitrev_d    = bitrev_q;
    data_d      = data_q;
    we_d        = '0;
    addr_d      = addr_q;
    frame_cnt_d = frame_cnt_q;

    if (accept) begin
      data_d = iDATA;
      if (idx_q == '0) begin
        mode_d   = iMODE;
        bitrev_d = iBITREV;
      end
      // idx parks on the last index; it only returns to 0 when the FFT completes.
      if (idx_q != LAST_IDX) idx_d = idx_q + IDX_W'(1);
      for (int b = 0; b < N_BANK; b++) begin
        if (wr_bank == BANK_W'(b)) begin
          we_d[b]                       = 1'b1;
          addr_d[b*ADDR_W +: ADDR_W]    = wr_addr;
        end
      end
    end

    if (state_q == S_LAUNCH)              frame_cnt_d = frame_cnt_q + 8'd1;
    if (state_q == S_WAIT_FFT && iFFT_RDY) idx_d      = '0;
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      idx_q       <= '0;
      mode_q      <= 1'b0;
      bitrev_q    <= 1'b0;
      data_q      <= '0;
      we_q        <= '0;
      addr_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      idx_q       <= idx_d;
      mode_q      <= mode_d;
      bitrev_q    <= bitrev_d;
      data_q      <= data_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign oREADY     = ready;
  assign oDATA      = data_q;
  assign oWE        = we_q;
  assign oADDR_WR   = addr_q;
  assign oFRAME_CNT = frame_cnt_q;

endmodule
